// File: rtl/adma_desc_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : adma_desc_sequencer
//  Brief    : ADMA descriptor-chain sequencer. Walks a 96-bit descriptor
//             table in memory, issues transfer requests to the DMA engine,
//             follows link descriptors, and stops on invalid entries or on
//             a table overrun.
//  Revision : 1.0  initial release
// ============================================================================
module adma_desc_sequencer (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        abort,
   input  logic        Continue,
   input  logic [63:0] desc_base,
   output logic        mem_rd_req,
   output logic [63:0] mem_rd_addr,
   input  logic        mem_rd_ack,
   input  logic [95:0] mem_rd_data,
   output logic        TRAN,
   output logic [63:0] data_address,
   output logic [16:0] length,
   output logic [5:0]  descriptor_index,
   input  logic        TFC,
   output logic        STOP,
   output logic        int_req,
   output logic        done,
   output logic        busy
);

   localparam logic [63:0] c_desc_stride = 64'd16;
   localparam logic [5:0]  c_last_index  = 6'd63;
   localparam logic [16:0] c_max_length  = 17'h1_0000;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      FETCH    = 3'd1,
      WAIT_ACK = 3'd2,
      DECODE   = 3'd3,
      XFER     = 3'd4,
      STOP_ST  = 3'd5,
      DONE_ST  = 3'd6
   } state_t;

   state_t      state_q, state_d;
   logic [63:0] desc_addr_q, desc_addr_d;
   logic [5:0]  index_q, index_d;
   logic [95:0] word_q, word_d;
   logic [63:0] data_address_q, data_address_d;
   logic [16:0] length_q, length_d;

   // Fields of the registered descriptor word
   logic [63:0] w_desc_addr;
   logic [15:0] w_desc_len;
   logic        w_valid;
   logic        w_end;
   logic        w_int;
   logic [1:0]  w_act;
   logic        w_at_last;
   logic        w_unused_attr;

   // Retirement of the current descriptor (nop/link in DECODE, TFC in XFER)
   logic        w_retire;
   logic [63:0] w_retire_addr;

   assign w_desc_addr   = word_q[95:32];
   assign w_desc_len    = word_q[31:16];
   assign w_valid       = word_q[0];
   assign w_end         = word_q[1];
   assign w_int         = word_q[2];
   assign w_act         = word_q[5:4];
   assign w_at_last     = (index_q == c_last_index);
   // Reserved attribute bits carry no meaning and are deliberately ignored
   assign w_unused_attr = ^{word_q[15:6], word_q[3]};

   // Next-state and datapath updates; abort outside IDLE overrides everything
   always_comb begin
      state_d        = state_q;
      desc_addr_d    = desc_addr_q;
      index_d        = index_q;
      word_d         = word_q;
      data_address_d = data_address_q;
      length_d       = length_q;
      w_retire       = 1'b0;
      w_retire_addr  = desc_addr_q + c_desc_stride;

      if (abort && (state_q != IDLE)) begin
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  desc_addr_d = desc_base;
                  index_d     = 6'd0;
                  state_d     = FETCH;
               end
            end
            FETCH: begin
               // Request is raised here; the ack is only honoured in WAIT_ACK
               state_d = WAIT_ACK;
            end
            WAIT_ACK: begin
               if (mem_rd_ack) begin
                  word_d  = mem_rd_data;
                  state_d = DECODE;
               end
            end
            DECODE: begin
               if (!w_valid) begin
                  state_d = STOP_ST;
               end else if (w_act == 2'b10) begin
                  data_address_d = w_desc_addr;
                  length_d       = (w_desc_len == 16'd0) ? c_max_length : {1'b0, w_desc_len};
                  state_d        = XFER;
               end else begin
                  w_retire      = 1'b1;
                  w_retire_addr = (w_act == 2'b11) ? w_desc_addr : desc_addr_q + c_desc_stride;
               end
            end
            XFER: begin
               if (TFC) begin
                  w_retire = 1'b1;
               end
            end
            STOP_ST: begin
               if (Continue) begin
                  if (w_at_last) begin
                     state_d = DONE_ST;
                  end else begin
                     desc_addr_d = desc_addr_q + c_desc_stride;
                     index_d     = index_q + 6'd1;
                     state_d     = FETCH;
                  end
               end
            end
            DONE_ST: begin
               state_d = IDLE;
            end
            default: begin
               state_d = IDLE;
            end
         endcase

         // Index saturates at the last table slot; running past it without
         // an END marker is reported as an overrun stop.
         if (w_retire) begin
            if (w_end) begin
               desc_addr_d = w_retire_addr;
               index_d     = w_at_last ? index_q : index_q + 6'd1;
               state_d     = DONE_ST;
            end else if (w_at_last) begin
               state_d = STOP_ST;
            end else begin
               desc_addr_d = w_retire_addr;
               index_d     = index_q + 6'd1;
               state_d     = FETCH;
            end
         end
      end
   end

   // State and datapath registers with asynchronous active-low reset
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q        <= IDLE;
         desc_addr_q    <= 64'd0;
         index_q        <= 6'd0;
         word_q         <= 96'd0;
         data_address_q <= 64'd0;
         length_q       <= 17'd0;
      end else begin
         state_q        <= state_d;
         desc_addr_q    <= desc_addr_d;
         index_q        <= index_d;
         word_q         <= word_d;
         data_address_q <= data_address_d;
         length_q       <= length_d;
      end
   end

   // Handshake levels follow the state; int_req fires in the TFC cycle itself
   assign mem_rd_req       = (state_q == FETCH) || (state_q == WAIT_ACK);
   assign mem_rd_addr      = desc_addr_q;
   assign TRAN             = (state_q == XFER);
   assign STOP             = (state_q == STOP_ST);
   assign done             = (state_q == DONE_ST);
   assign busy             = (state_q != IDLE);
   assign int_req          = TRAN && TFC && w_int && !abort;
   assign data_address     = data_address_q;
   assign length           = length_q;
   assign descriptor_index = index_q;

endmodule
`default_nettype wire

// File: tb/tb_adma_desc_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_adma_desc_sequencer
//  Brief    : Self-checking bench for adma_desc_sequencer. A transaction-level
//             walk of the descriptor table predicts reads, transfers,
//             interrupts, stops and the final index of each chain.
//  Revision : 1.0  initial release
// ============================================================================
module tb_adma_desc_sequencer;

   localparam int c_half = 5;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic        cont = 1'b0;
   logic [63:0] desc_base = 64'd0;
   logic        mem_rd_req;
   logic [63:0] mem_rd_addr;
   logic        ack = 1'b0;
   logic [95:0] rd_data = 96'd0;
   logic        TRAN;
   logic [63:0] data_address;
   logic [16:0] length;
   logic [5:0]  descriptor_index;
   logic        tfc = 1'b0;
   logic        STOP;
   logic        int_req;
   logic        done;
   logic        busy;

   always #c_half clk = ~clk;

   adma_desc_sequencer dut (
      .clk              (clk),
      .reset            (reset),
      .start            (start),
      .abort            (abort),
      .Continue         (cont),
      .desc_base        (desc_base),
      .mem_rd_req       (mem_rd_req),
      .mem_rd_addr      (mem_rd_addr),
      .mem_rd_ack       (ack),
      .mem_rd_data      (rd_data),
      .TRAN             (TRAN),
      .data_address     (data_address),
      .length           (length),
      .descriptor_index (descriptor_index),
      .TFC              (tfc),
      .STOP             (STOP),
      .int_req          (int_req),
      .done             (done),
      .busy             (busy)
   );

   typedef struct packed {
      logic [63:0] a;
      logic [16:0] l;
      logic [5:0]  i;
   } ev_t;

   ev_t exp_rd[$], exp_xf[$], exp_int[$], exp_stop[$];
   ev_t obs_rd[$], obs_xf[$], obs_int[$], obs_stop[$];

   logic [95:0] mem [logic [63:0]];

   int n_cmp = 0;
   int n_bad = 0;

   // Responder / monitor state
   int  req_age = 0, ack_lat = 2, tran_age = 0, tfc_lat = 1, stop_age = 0, cont_lat = 1;
   bit  noise_en = 1'b1, tfc_hold = 1'b0, abort_with_tfc = 1'b0;
   bit  prev_req, prev_tran, prev_stop, prev_done, prev_tfc;
   bit  done_seen, done_prev_tfc;
   logic [5:0] done_idx;
   int  exp_final_idx;
   bit  exp_end_tran;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic ev_t mk_ev(input logic [63:0] a, input logic [16:0] l, input logic [5:0] i);
      ev_t e;
      e.a = a;
      e.l = l;
      e.i = i;
      return e;
   endfunction

   function automatic logic [95:0] mem_word(input logic [63:0] a);
      return mem.exists(a) ? mem[a] : 96'd0;
   endfunction

   // Reference: walk the table as the descriptor rules describe, assuming
   // every stop is eventually resumed with Continue.
   task automatic model_chain(input logic [63:0] base);
      logic [63:0] addr, nxt;
      logic [95:0] w;
      logic [15:0] at;
      int          idx;
      bit          fin;
      exp_rd.delete(); exp_xf.delete(); exp_int.delete(); exp_stop.delete();
      addr = base; idx = 0; fin = 1'b0; exp_end_tran = 1'b0; exp_final_idx = 0;
      for (int guard = 0; guard < 80 && !fin; guard++) begin
         exp_rd.push_back(mk_ev(addr, 17'd0, idx[5:0]));
         w  = mem_word(addr);
         at = w[15:0];
         if (!at[0]) begin
            exp_stop.push_back(mk_ev(64'd0, 17'd0, idx[5:0]));
            if (idx == 63) begin
               exp_final_idx = 63; fin = 1'b1;
            end else begin
               addr = addr + 64'd16; idx++;
            end
         end else begin
            if (at[5:4] == 2'b10) begin
               exp_xf.push_back(mk_ev(w[95:32], (w[31:16] == 16'd0) ? 17'd65536 : {1'b0, w[31:16]}, idx[5:0]));
               if (at[2]) exp_int.push_back(mk_ev(64'd0, 17'd0, idx[5:0]));
               nxt = addr + 64'd16;
            end else begin
               nxt = (at[5:4] == 2'b11) ? w[95:32] : addr + 64'd16;
            end
            if (at[1]) begin
               exp_final_idx = (idx == 63) ? 63 : idx + 1;
               exp_end_tran  = (at[5:4] == 2'b10);
               fin = 1'b1;
            end else if (idx == 63) begin
               exp_stop.push_back(mk_ev(64'd0, 17'd0, 6'd63));
               exp_final_idx = 63; fin = 1'b1;
            end else begin
               idx++; addr = nxt;
            end
         end
      end
   endtask

   // One clock: drive inputs on the falling edge, sample 1 ns later
   task automatic step(input bit do_start, input logic [63:0] base);
      @(negedge clk);
      if (mem_rd_req) begin
         req_age++;
         if (req_age == 1) ack_lat = $urandom_range(2, 4);
      end else req_age = 0;
      ack     = mem_rd_req && (req_age >= ack_lat);
      rd_data = ack ? mem_word(mem_rd_addr) : {$urandom, $urandom, $urandom};

      if (TRAN) begin
         tran_age++;
         if (tran_age == 1) tfc_lat = $urandom_range(1, 4);
         tfc = !tfc_hold && (tran_age >= tfc_lat);
      end else begin
         tran_age = 0;
         tfc = noise_en && ($urandom_range(0, 15) == 0);
      end
      abort = abort_with_tfc && TRAN && tfc;

      if (STOP) begin
         stop_age++;
         if (stop_age == 1) cont_lat = $urandom_range(1, 3);
         cont = (stop_age >= cont_lat);
      end else begin
         stop_age = 0;
         cont = noise_en && ($urandom_range(0, 15) == 0);
      end

      start     = do_start || (noise_en && busy && ($urandom_range(0, 19) == 0));
      desc_base = do_start ? base : {$urandom, $urandom};
      #1;
      if (mem_rd_req && !prev_req) obs_rd.push_back(mk_ev(mem_rd_addr, 17'd0, descriptor_index));
      if (TRAN && !prev_tran) obs_xf.push_back(mk_ev(data_address, length, descriptor_index));
      if (prev_tran && !TRAN) chk("tran_held_until_tfc", prev_tfc, 1);
      if (int_req) begin
         obs_int.push_back(mk_ev(64'd0, 17'd0, descriptor_index));
         chk("int_only_on_tfc", {TRAN, tfc}, 2'b11);
      end
      if (STOP && !prev_stop) obs_stop.push_back(mk_ev(64'd0, 17'd0, descriptor_index));
      if (prev_done) chk("done_single_cycle", done, 0);
      if (done && !done_seen) begin
         done_seen = 1'b1; done_idx = descriptor_index; done_prev_tfc = prev_tfc;
      end
      prev_req = mem_rd_req; prev_tran = TRAN; prev_stop = STOP;
      prev_done = done; prev_tfc = tfc;
   endtask

   task automatic clear_obs();
      obs_rd.delete(); obs_xf.delete(); obs_int.delete(); obs_stop.delete();
      prev_req = 0; prev_tran = 0; prev_stop = 0; prev_done = 0; prev_tfc = 0;
      done_seen = 0; done_prev_tfc = 0; done_idx = 6'd0;
   endtask

   task automatic run_chain(input logic [63:0] base, input string name);
      model_chain(base);
      clear_obs();
      step(1'b1, base);
      for (int g = 0; g < 4000 && !done_seen; g++) step(1'b0, 64'd0);
      chk($sformatf("%s:done_seen", name), done_seen, 1);
      chk($sformatf("%s:n_reads", name), obs_rd.size(), exp_rd.size());
      chk($sformatf("%s:n_xfers", name), obs_xf.size(), exp_xf.size());
      chk($sformatf("%s:n_ints", name), obs_int.size(), exp_int.size());
      chk($sformatf("%s:n_stops", name), obs_stop.size(), exp_stop.size());
      for (int k = 0; k < exp_rd.size() && k < obs_rd.size(); k++)
         chk($sformatf("%s:rd%0d", name, k), obs_rd[k], exp_rd[k]);
      for (int k = 0; k < exp_xf.size() && k < obs_xf.size(); k++)
         chk($sformatf("%s:xf%0d", name, k), obs_xf[k], exp_xf[k]);
      for (int k = 0; k < exp_int.size() && k < obs_int.size(); k++)
         chk($sformatf("%s:int%0d", name, k), obs_int[k], exp_int[k]);
      for (int k = 0; k < exp_stop.size() && k < obs_stop.size(); k++)
         chk($sformatf("%s:stop%0d", name, k), obs_stop[k], exp_stop[k]);
      chk($sformatf("%s:final_index", name), done_idx, exp_final_idx);
      if (exp_end_tran) chk($sformatf("%s:done_after_tfc", name), done_prev_tfc, 1);
      step(1'b0, 64'd0);
      step(1'b0, 64'd0);
      chk($sformatf("%s:idle_after_done", name), busy, 0);
   endtask

   function automatic logic [95:0] mk_desc(input logic [63:0] a, input logic [15:0] l, input logic [15:0] at);
      return {a, l, at};
   endfunction

   // Random chain: 1..8 valid descriptors, sprinkled with invalid entries
   task automatic gen_random(output logic [63:0] base);
      logic [63:0] addr, tgt, r;
      logic [31:0] junk;
      logic [15:0] len, at;
      logic [1:0]  act;
      int          ndesc, k, kind;
      bit          last;
      mem.delete();
      r = {$urandom, $urandom}; r[3:0] = 4'h0; base = r; addr = r;
      ndesc = $urandom_range(1, 8); k = 0;
      for (int guard = 0; guard < 40 && k < ndesc; guard++) begin
         kind = $urandom_range(0, 9);
         last = (k == ndesc - 1);
         junk = $urandom;
         tgt  = {$urandom, $urandom}; tgt[3:0] = 4'h0;
         len  = ($urandom_range(0, 7) == 0) ? 16'd0 : junk[31:16];
         if (kind == 0 && !last) begin
            at = junk[15:0]; at[0] = 1'b0;
            mem[addr] = mk_desc(tgt, len, at);
            addr = addr + 64'd16;
         end else begin
            if (kind <= 5)      act = 2'b10;
            else if (kind <= 7) act = {1'b0, junk[20]};
            else                act = 2'b11;
            at = {junk[15:6], act, junk[3], junk[2], last, 1'b1};
            mem[addr] = mk_desc(tgt, len, at);
            addr = (act == 2'b11) ? tgt : addr + 64'd16;
            k++;
         end
      end
   endtask

   logic [63:0] rbase;
   logic [31:0] rj;
   bit          hit;

   initial begin
      // ---- reset state, with inputs toggling ----
      reset = 1'b0; start = 1'b1; tfc = 1'b1; cont = 1'b1; ack = 1'b1;
      desc_base = 64'hDEAD_BEEF_0000_1000; rd_data = {3{32'hA5A5_5A5A}};
      repeat (3) @(negedge clk);
      #1;
      chk("rst:mem_rd_req", mem_rd_req, 0);
      chk("rst:mem_rd_addr", mem_rd_addr, 0);
      chk("rst:TRAN", TRAN, 0);
      chk("rst:data_address", data_address, 0);
      chk("rst:length", length, 0);
      chk("rst:index", descriptor_index, 0);
      chk("rst:STOP", STOP, 0);
      chk("rst:int_req", int_req, 0);
      chk("rst:done", done, 0);
      chk("rst:busy", busy, 0);
      start = 0; tfc = 0; cont = 0; ack = 0;
      @(negedge clk);
      reset = 1'b1;

      // ---- single transfer with END ----
      mem.delete();
      mem[64'h1000] = mk_desc(64'h8000, 16'h0200, 16'h0023);
      run_chain(64'h1000, "single");
      if (obs_rd.size() > 0) chk("single:rd_addr", obs_rd[0].a, 64'h1000);
      if (obs_xf.size() > 0) begin
         chk("single:data_address", obs_xf[0].a, 64'h8000);
         chk("single:length", obs_xf[0].l, 17'h200);
      end
      chk("single:index_at_done", done_idx, 1);

      // ---- three transfers ----
      mem.delete();
      mem[64'h1000] = mk_desc(64'hA000, 16'h0010, 16'h0021);
      mem[64'h1010] = mk_desc(64'hB000, 16'h0020, 16'h0021);
      mem[64'h1020] = mk_desc(64'hC000, 16'h0030, 16'h0023);
      run_chain(64'h1000, "three");
      chk("three:n_xfers_const", obs_xf.size(), 3);
      if (obs_rd.size() > 2) chk("three:rd2_addr", obs_rd[2].a, 64'h1020);
      if (obs_xf.size() > 2) chk("three:xf2_index", obs_xf[2].i, 2);

      // ---- link then zero-length transfer ----
      mem.delete();
      mem[64'h1000] = mk_desc(64'h4000, 16'h0000, 16'h0031);
      mem[64'h4000] = mk_desc(64'h9000, 16'h0000, 16'h0023);
      run_chain(64'h1000, "link");
      if (obs_rd.size() > 1) chk("link:rd1_addr", obs_rd[1].a, 64'h4000);
      if (obs_xf.size() > 0) chk("link:len_65536", obs_xf[0].l, 17'd65536);

      // ---- invalid descriptor, resumed with Continue ----
      mem.delete();
      mem[64'h1000] = mk_desc(64'hA000, 16'h0040, 16'h0021);
      mem[64'h1010] = mk_desc(64'hFFFF, 16'hFFFF, 16'h0000);
      mem[64'h1020] = mk_desc(64'hB000, 16'h0080, 16'h0027);
      run_chain(64'h1000, "invalid");
      chk("invalid:n_stops_const", obs_stop.size(), 1);
      if (obs_rd.size() > 2) chk("invalid:rd2_addr", obs_rd[2].a, 64'h1020);

      // ---- table overrun: 64 nops without END ----
      mem.delete();
      for (int k = 0; k < 64; k++) begin
         rj = $urandom;
         mem[64'h1000 + 64'(k) * 64'd16] = mk_desc({$urandom, $urandom}, rj[31:16],
                                                  {rj[15:6], 1'b0, rj[4], rj[3], rj[2], 1'b0, 1'b1});
      end
      run_chain(64'h1000, "overrun");
      chk("overrun:n_reads_const", obs_rd.size(), 64);
      if (obs_stop.size() > 0) chk("overrun:stop_index", obs_stop[0].i, 63);

      // ---- randomized chains ----
      for (int t = 0; t < 25; t++) begin
         gen_random(rbase);
         run_chain(rbase, $sformatf("rand%0d", t));
      end

      // ---- abort coinciding with TFC ----
      noise_en = 1'b0; abort_with_tfc = 1'b1;
      mem.delete();
      mem[64'h1000] = mk_desc(64'h8000, 16'h0200, 16'h0027);
      clear_obs();
      hit = 1'b0;
      step(1'b1, 64'h1000);
      for (int g = 0; g < 100 && !hit; g++) begin
         step(1'b0, 64'd0);
         if (abort) begin
            hit = 1'b1;
            chk("abort:int_req_suppressed", int_req, 0);
            step(1'b0, 64'd0);
            chk("abort:TRAN", TRAN, 0);
            chk("abort:busy", busy, 0);
            chk("abort:done", done, 0);
            chk("abort:mem_rd_req", mem_rd_req, 0);
         end
      end
      chk("abort:reached", hit, 1);
      abort_with_tfc = 1'b0;
      repeat (3) step(1'b0, 64'd0);
      chk("abort:no_done", done_seen, 0);

      // ---- reset asserted mid-transfer ----
      tfc_hold = 1'b1;
      clear_obs();
      hit = 1'b0;
      step(1'b1, 64'h1000);
      for (int g = 0; g < 100 && !hit; g++) begin
         step(1'b0, 64'd0);
         if (TRAN) hit = 1'b1;
      end
      chk("rstx:reached_xfer", hit, 1);
      #1 tfc = 1'b1;
      #1 chk("rstx:int_before_reset", int_req, 1);
      reset = 1'b0;
      #1;
      chk("rstx:TRAN", TRAN, 0);
      chk("rstx:mem_rd_req", mem_rd_req, 0);
      chk("rstx:int_req", int_req, 0);
      chk("rstx:busy", busy, 0);
      @(negedge clk);
      #1 chk("rstx:done", done, 0);
      tfc = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      tfc_hold = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
